spi_perif_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single SPI peripheral master among `NUM_REQ` requesters. It drives the master's status register and transmit word, demultiplexes the master's single slave-select onto per-requester chip-selects, and captures the 2-word response. It clears the operation bit on completion so transfers never repeat. A watchdog aborts hung transfers through the master's reset.

---
 rtl/spi_perif_arbiter.sv | 172 +++++++++++++++++
 tb/tb_spi_perif_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_perif_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master among NUM_REQ requesters:
// grants, drives the master status/data, demuxes slave-select, captures the response, aborts hung transfers.
module spi_perif_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 4096,
   parameter int unsigned MIN_GAP    = 4
) (
   input  logic                            spi_clk_i,
   input  logic                            spi_rst_i,
   input  logic                            en_i,
   input  logic [NUM_REQ-1:0]              req_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
   input  logic [NUM_REQ*4-1:0]            req_cfg_i,
   output logic [NUM_REQ-1:0]              gnt_o,
   output logic [NUM_REQ-1:0]              done_o,
   output logic [NUM_REQ-1:0]              err_o,
   output logic [2*DATA_WIDTH-1:0]         rx_data_o,
   output logic                            busy_o,
   output logic [NUM_REQ-1:0]              cs_n_o,
   output logic [5:0]                      spi_statusreg_o,
   output logic [DATA_WIDTH-1:0]           spi_data_o,
   input  logic                            spi_doneflag_i,
   input  logic [2*DATA_WIDTH-1:0]         spi_data_i,
   input  logic                            ss_i,
   output logic                            spi_abort_o
);

   localparam int unsigned IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_MAX = (TIMEOUT > MIN_GAP) ? TIMEOUT : MIN_GAP;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUSY    = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_GAP     = 2'd3;

   logic [1:0]            state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [IW-1:0]         rr_ptr, rr_ptr_n, idx, idx_n, next_ptr;
   logic                  pick_vld;
   logic [IW-1:0]         pick_idx;
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
   logic [3:0]            cfg_arr  [NUM_REQ];

   logic [NUM_REQ-1:0]    gnt_n, done_n, err_n;
   logic [2*DATA_WIDTH-1:0] rx_n;
   logic [DATA_WIDTH-1:0] data_n;
   logic [2:0]            div_n;
   logic                  fbo_n, op_n, en_n, busy_n, abort_n;

   // Per-requester payload slices; chip-select follows ss_i only for the granted requester.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign data_arr[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
      assign cfg_arr[g]  = req_cfg_i[g*4 +: 4];
      assign cs_n_o[g]   = gnt_o[g] ? ss_i : 1'b1;
   end

   // First pending request at or after rr_ptr, wrapping.
   always_comb begin
      int unsigned j;
      j        = 0;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = 32'(rr_ptr) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!pick_vld && req_i[IW'(j)]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(j);
         end
      end
   end

   assign next_ptr = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      rr_ptr_n = rr_ptr;
      idx_n    = idx;
      gnt_n    = gnt_o;
      done_n   = '0;
      err_n    = '0;
      rx_n     = rx_data_o;
      data_n   = spi_data_o;
      div_n    = spi_statusreg_o[4:2];
      fbo_n    = spi_statusreg_o[1];
      op_n     = spi_statusreg_o[0];
      abort_n  = 1'b0;
      case (state)
         S_IDLE: begin
            if (en_i && pick_vld) begin
               state_n = S_BUSY;
               cnt_n   = '0;
               idx_n   = pick_idx;
               gnt_n   = NUM_REQ'(1) << pick_idx;
               data_n  = data_arr[pick_idx];
               div_n   = cfg_arr[pick_idx][3:1];
               fbo_n   = cfg_arr[pick_idx][0];
               op_n    = 1'b1;
            end
         end
         S_BUSY: begin
            // Done takes priority over a coincident timeout.
            if (spi_doneflag_i) begin
               op_n     = 1'b0;
               state_n  = S_CAPTURE;
               rr_ptr_n = next_ptr;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               op_n     = 1'b0;
               abort_n  = 1'b1;
               err_n    = gnt_o;
               gnt_n    = '0;
               state_n  = S_GAP;
               cnt_n    = '0;
               rr_ptr_n = next_ptr;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_CAPTURE: begin
            rx_n    = spi_data_i;
            done_n  = gnt_o;
            gnt_n   = '0;
            state_n = S_GAP;
            cnt_n   = '0;
         end
         default: begin
            if (cnt == CW'(MIN_GAP - 1)) begin
               state_n = S_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
      endcase
      en_n   = (state_n == S_BUSY || state_n == S_CAPTURE) ? 1'b1 : en_i;
      busy_n = (state_n != S_IDLE);
   end

   always_ff @(posedge spi_clk_i) begin
      if (!spi_rst_i) begin
         state           <= S_IDLE;
         cnt             <= '0;
         rr_ptr          <= '0;
         idx             <= '0;
         gnt_o           <= '0;
         done_o          <= '0;
         err_o           <= '0;
         rx_data_o       <= '0;
         busy_o          <= 1'b0;
         spi_statusreg_o <= '0;
         spi_data_o      <= '0;
         spi_abort_o     <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         rr_ptr          <= rr_ptr_n;
         idx             <= idx_n;
         gnt_o           <= gnt_n;
         done_o          <= done_n;
         err_o           <= err_n;
         rx_data_o       <= rx_n;
         busy_o          <= busy_n;
         spi_statusreg_o <= {en_n, div_n, fbo_n, op_n};
         spi_data_o      <= data_n;
         spi_abort_o     <= abort_n;
      end
   end

endmodule

// File: tb/tb_spi_perif_arbiter.sv
// Directed bench for spi_perif_arbiter: transaction-level model with per-cycle compare,
// a small SPI master model, and literal checks for the key scenarios.
module tb_spi_perif_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int TO  = 16;
   localparam int MG  = 4;
   localparam int LAT = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [N-1:0]  req = '0;
   logic [DW-1:0] tdata [N];
   logic [3:0]    tcfg  [N];
   logic [N*DW-1:0] req_data;
   logic [N*4-1:0]  req_cfg;
   logic [N-1:0]  gnt, done, err, cs_n;
   logic [2*DW-1:0] rx;
   logic          busy, abort;
   logic [5:0]    stat;
   logic [DW-1:0] sdata_o;
   logic          df = 1'b0;
   logic [2*DW-1:0] sd_in = '0;
   logic          ss = 1'b1;

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         req_data[k*DW +: DW] = tdata[k];
         req_cfg[k*4 +: 4]    = tcfg[k];
      end
   end

   spi_perif_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO), .MIN_GAP(MG)) dut (
      .spi_clk_i(clk), .spi_rst_i(rst_n), .en_i(en), .req_i(req),
      .req_data_i(req_data), .req_cfg_i(req_cfg),
      .gnt_o(gnt), .done_o(done), .err_o(err), .rx_data_o(rx), .busy_o(busy),
      .cs_n_o(cs_n), .spi_statusreg_o(stat), .spi_data_o(sdata_o),
      .spi_doneflag_i(df), .spi_data_i(sd_in), .ss_i(ss), .spi_abort_o(abort)
   );

   // SPI master model: starts on op=1, holds ss low LAT cycles, pulses done, then updates its data register.
   logic [2*DW-1:0] resp = 16'h3C7E;
   logic            mute = 1'b0;
   int              ms = 0, mc = 0;
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         ms = 0; ss = 1'b1; df = 1'b0; sd_in = '0; mc = 0;
      end else begin
         case (ms)
            0: if (stat[0] && !mute) begin ms = 1; mc = 0; ss = 1'b0; end
            1: begin
               mc++;
               if (mc == LAT) begin ss = 1'b1; df = 1'b1; ms = 2; end
            end
            default: begin df = 1'b0; sd_in = resp; ms = 0; end
         endcase
      end
   end

   // Transaction-level reference: tracks owner, grant time and the earliest cycle a new grant is allowed.
   logic [N-1:0]    e_gnt, e_done, e_err;
   logic [2*DW-1:0] e_rx;
   logic            e_busy, e_abort;
   logic [5:0]      e_stat;
   logic [DW-1:0]   e_data;
   bit              chk_on = 1'b0;
   int m_ptr = 0, m_own = 0, m_tg = 0, m_ok = 0, mcyc = 0;
   bit m_xfer = 1'b0, m_cap = 1'b0;
   always @(posedge clk) begin
      bit found;
      e_done = '0; e_err = '0; e_abort = 1'b0;
      if (!rst_n) begin
         chk_on = 1'b1;
         e_gnt = '0; e_rx = '0; e_stat = '0; e_data = '0;
         m_ptr = 0; m_xfer = 1'b0; m_cap = 1'b0; m_ok = mcyc + 1;
      end else begin
         if (m_cap) begin
            e_rx = sd_in; e_done[m_own] = 1'b1; e_gnt = '0;
            m_cap = 1'b0; m_ok = mcyc + MG + 1;
         end else if (m_xfer) begin
            if (df) begin
               e_stat[0] = 1'b0; m_cap = 1'b1; m_xfer = 1'b0; m_ptr = (m_own + 1) % N;
            end else if (mcyc - m_tg == TO) begin
               e_stat[0] = 1'b0; e_abort = 1'b1; e_err[m_own] = 1'b1; e_gnt = '0;
               m_xfer = 1'b0; m_ptr = (m_own + 1) % N; m_ok = mcyc + MG + 1;
            end
         end else if (mcyc >= m_ok && en) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
               int k;
               k = (m_ptr + i) % N;
               if (!found && req[2'(k)]) begin found = 1'b1; m_own = k; end
            end
            if (found) begin
               m_xfer = 1'b1; m_tg = mcyc;
               e_gnt = '0; e_gnt[m_own] = 1'b1;
               e_data = tdata[2'(m_own)];
               e_stat[4:1] = tcfg[2'(m_own)];
               e_stat[0] = 1'b1;
            end
         end
         e_stat[5] = (m_xfer || m_cap) ? 1'b1 : en;
      end
      e_busy = m_xfer || m_cap || (mcyc + 1 < m_ok);
      mcyc++;
   end

   int n_vec = 0, n_fail = 0, tcnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One cycle: compare every output against the model at the falling edge, then step past the rising edge.
   task automatic tick();
      logic [N-1:0] e_cs;
      @(negedge clk);
      if (chk_on) begin
         e_cs = '1;
         for (int k = 0; k < N; k++) if (e_gnt[k]) e_cs[k] = ss;
         chk("gnt", 32'(gnt), 32'(e_gnt));
         chk("done", 32'(done), 32'(e_done));
         chk("err", 32'(err), 32'(e_err));
         chk("rx_data", 32'(rx), 32'(e_rx));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("cs_n", 32'(cs_n), 32'(e_cs));
         chk("statusreg", 32'(stat), 32'(e_stat));
         chk("spi_data", 32'(sdata_o), 32'(e_data));
         chk("abort", 32'(abort), 32'(e_abort));
      end
      @(posedge clk);
      #2;
      tcnt++;
   endtask

   task automatic wait_gnt(output int t);
      int k = 0;
      while (gnt == '0 && k < 40) begin tick(); k++; end
      chk("gnt_wait", 32'(gnt != '0), 32'd1);
      t = tcnt;
   endtask

   task automatic wait_done(output int t);
      int k = 0;
      while (done == '0 && k < 40) begin tick(); k++; end
      chk("done_wait", 32'(done != '0), 32'd1);
      t = tcnt;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 40) begin tick(); k++; end
      chk("idle_wait", 32'(busy), 32'd0);
      tick();
   endtask

   initial begin
      int t0, t1, tp, g_idx, k;
      int order [5];
      tdata[0] = 8'hA5; tdata[1] = 8'h22; tdata[2] = 8'h33; tdata[3] = 8'h44;
      tcfg[0]  = 4'b0011; tcfg[1] = 4'h5; tcfg[2] = 4'hA; tcfg[3] = 4'hE;

      tick(); tick();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_cs_n", 32'(cs_n), 32'hF);
      chk("rst_status", 32'(stat), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single request with full status/data/response check.
      en = 1'b1; req = 4'b0001;
      wait_gnt(t0);
      chk("t1_gnt", 32'(gnt), 32'h1);
      chk("t1_status", 32'(stat), 32'b100111);
      chk("t1_data", 32'(sdata_o), 32'hA5);
      k = 0;
      while (!df && k < 40) begin tick(); k++; end
      tick();
      chk("t1_op_clear", 32'(stat[0]), 32'd0);
      wait_done(t1);
      chk("t1_done", 32'(done), 32'h1);
      chk("t1_rx", 32'(rx), 32'h3C7E);
      req = '0;
      tick();
      chk("t1_done_pulse", 32'(done), 32'h0);
      wait_idle();

      // Round-robin from a fresh pointer with all requesters active.
      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      resp = 16'h1234; req = 4'b1111; tp = 0;
      for (int g = 0; g < 5; g++) begin
         wait_gnt(t0);
         g_idx = 0;
         for (int b = 0; b < N; b++) if (gnt[b]) g_idx = b;
         order[g] = g_idx;
         if (g > 0) chk("rr_gap", 32'(t0 - tp >= MG + 1), 32'd1);
         if (g == 4) req = '0;
         wait_done(tp);
      end
      chk("rr_0", 32'(order[0]), 32'd0);
      chk("rr_1", 32'(order[1]), 32'd1);
      chk("rr_2", 32'(order[2]), 32'd2);
      chk("rr_3", 32'(order[3]), 32'd3);
      chk("rr_4", 32'(order[4]), 32'd0);
      wait_idle();

      // Hung transfer: abort and error exactly TIMEOUT cycles after the grant.
      mute = 1'b1; req = 4'b0100;
      wait_gnt(t0);
      chk("to_gnt", 32'(gnt), 32'h4);
      k = 0;
      while (err == '0 && k < 40) begin tick(); k++; end
      t1 = tcnt;
      chk("to_err", 32'(err), 32'h4);
      chk("to_abort", 32'(abort), 32'd1);
      chk("to_latency", 32'(t1 - t0), 32'(TO));
      chk("to_no_done", 32'(done), 32'd0);
      req = '0;
      wait_idle();
      mute = 1'b0;

      // Enable dropped mid-transfer: completes, then no new grant until re-enabled.
      req = 4'b1000;
      wait_gnt(t0);
      chk("en_gnt", 32'(gnt), 32'h8);
      en = 1'b0;
      wait_done(t1);
      chk("en_done", 32'(done), 32'h8);
      repeat (12) tick();
      chk("en_hold_gnt", 32'(gnt), 32'd0);
      chk("en_hold_busy", 32'(busy), 32'd0);
      en = 1'b1;
      wait_gnt(t0);
      chk("en_regnt", 32'(gnt), 32'h8);
      req = '0;
      wait_done(t1);
      chk("en_drop_req_done", 32'(done), 32'h8);
      wait_idle();

      // Reset in the middle of a transfer, then a fresh grant from pointer 0.
      req = 4'b0010;
      wait_gnt(t0);
      chk("rs_gnt", 32'(gnt), 32'h2);
      tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("rs_gnt0", 32'(gnt), 32'd0);
      chk("rs_busy0", 32'(busy), 32'd0);
      chk("rs_status0", 32'(stat), 32'd0);
      chk("rs_cs_n", 32'(cs_n), 32'hF);
      rst_n = 1'b1; req = 4'b0100;
      wait_gnt(t0);
      chk("rs_regnt", 32'(gnt), 32'h4);
      wait_done(t1);
      chk("rs_done", 32'(done), 32'h4);
      req = '0;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
